// File: rtl/shake_squeeze_if.sv
// Handshake bundle between the SHAKE squeeze reader, the permutation core and the
// output consumer. The slave modport is the squeeze block's view.
interface shake_squeeze_if #(
  parameter int LEN_W = 16
);
  logic                     start;
  logic [LEN_W-1:0]         out_words;
  logic                     busy;
  logic [0:4][0:4][63:0]    A_in;
  logic                     st_valid;
  logic                     st_ready;
  logic                     perm_req;
  logic [63:0]              out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     done;

  modport slave (
    input  start, out_words, A_in, st_valid, out_ready,
    output busy, st_ready, perm_req, out_data, out_valid, out_last, done
  );

  modport master (
    output start, out_words, A_in, st_valid, out_ready,
    input  busy, st_ready, perm_req, out_data, out_valid, out_last, done
  );
endinterface

// File: rtl/shake_squeeze.sv
// SHAKE squeeze reader: captures the rate lanes of a permuted Keccak state and
// streams them as 64-bit words, asking the core for another permutation as needed.
module shake_squeeze #(
  parameter int RATE_LANES = 17,
  parameter int LEN_W      = 16
) (
  input  logic           clk,
  input  logic           rst,
  shake_squeeze_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_ST, EMIT, REQ} state_t;

  localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

  state_t            state, state_n;
  logic [LEN_W-1:0]  rem, rem_n;
  logic [4:0]        lane, lane_n;
  logic [4:0]        lane_inc;
  logic              cap;
  logic              busy_r, busy_n;
  logic              done_r, done_n;
  logic              perm_req_r, perm_req_n;
  logic              out_valid_r, out_valid_n;
  logic              out_last_r, out_last_n;
  logic [63:0]       out_data_r, out_data_n;
  logic [63:0]       flat [25];
  logic [63:0]       lane_buf [RATE_LANES];

  // FIPS 202 lane order: lane i sits at x = i mod 5, y = i div 5
  for (genvar y = 0; y < 5; y++) begin : g_y
    for (genvar x = 0; x < 5; x++) begin : g_x
      assign flat[x + 5*y] = bus.A_in[x][y];
    end
  end

  assign lane_inc     = lane + 5'd1;
  assign bus.st_ready = (state == WAIT_ST);
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.perm_req = perm_req_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last = out_last_r;
  assign bus.out_data = out_data_r;

  always_comb begin
    state_n     = state;
    rem_n       = rem;
    lane_n      = lane;
    cap         = 1'b0;
    busy_n      = busy_r;
    done_n      = 1'b0;
    perm_req_n  = 1'b0;
    out_valid_n = out_valid_r;
    out_last_n  = out_last_r;
    out_data_n  = out_data_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          rem_n = bus.out_words;
          if (bus.out_words == '0) begin
            done_n = 1'b1;
          end else begin
            busy_n  = 1'b1;
            state_n = WAIT_ST;
          end
        end
      end
      WAIT_ST: begin
        if (bus.st_valid) begin
          cap         = 1'b1;
          lane_n      = 5'd0;
          out_valid_n = 1'b1;
          out_data_n  = flat[0];
          out_last_n  = (rem == LEN_W'(1));
          state_n     = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          rem_n  = rem - LEN_W'(1);
          lane_n = lane_inc;
          if (rem == LEN_W'(1)) begin
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
            done_n      = 1'b1;
            busy_n      = 1'b0;
            state_n     = IDLE;
          end else if (lane == LAST_LANE) begin
            // rate exhausted with words still owed: ask the core to permute again
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
            perm_req_n  = 1'b1;
            state_n     = REQ;
          end else begin
            out_data_n = lane_buf[lane_inc];
            out_last_n = (rem == LEN_W'(2));
          end
        end
      end
      REQ: begin
        state_n = WAIT_ST;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      lane        <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      perm_req_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
      for (int i = 0; i < RATE_LANES; i++) lane_buf[i] <= '0;
    end else begin
      state       <= state_n;
      rem         <= rem_n;
      lane        <= lane_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
      perm_req_r  <= perm_req_n;
      out_valid_r <= out_valid_n;
      out_last_r  <= out_last_n;
      out_data_r  <= out_data_n;
      if (cap) begin
        for (int i = 0; i < RATE_LANES; i++) lane_buf[i] <= flat[i];
      end
    end
  end

endmodule

// File: tb/tb_shake_squeeze.sv
// Scoreboard bench for shake_squeeze: a core model supplies states and queues the
// words a SHAKE squeeze must produce; a monitor checks every transfer against them.
module tb_shake_squeeze;

  localparam int R  = 17;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shake_squeeze_if #(.LEN_W(LW)) bus ();

  shake_squeeze #(.RATE_LANES(R), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_perm   = 0;
  int   n_done   = 0;
  int   sq_xfers = 0;
  int   model_rem = 0;
  bit   core_en = 1'b0;
  bit   fixed_pat = 1'b0;
  bit   ready_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, need %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Permutation core model: hands over a state whenever the reader is ready and
  // queues the words of that state the squeeze still owes.
  initial begin
    bus.st_valid = 1'b0;
    bus.A_in     = '0;
    forever begin
      @(posedge clk); #1;
      bus.st_valid = 1'b0;
      if (core_en && !rst && bus.st_ready && ($urandom_range(3) != 0)) begin
        logic [63:0] lanes [25];
        int cnt;
        for (int i = 0; i < 25; i++)
          lanes[i] = fixed_pat ? 64'(i) * 64'h0101010101010101 : rnd64();
        for (int i = 0; i < 25; i++)
          bus.A_in[i % 5][i / 5] = lanes[i];
        cnt = (model_rem < R) ? model_rem : R;
        for (int k = 0; k < cnt; k++)
          exp_q.push_back('{lanes[k], ((model_rem - k) == 1)});
        model_rem -= cnt;
        bus.st_valid = 1'b1;
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = ready_rand ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Monitor: pulse counting, hold-while-stalled and scoreboard comparison
  initial begin
    logic        pv, pr, pl;
    logic [63:0] pd;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (bus.perm_req) n_perm++;
        if (bus.done) n_done++;
        if (pv && !pr) begin
          check("hold_valid", 64'(bus.out_valid), 64'd1);
          check("hold_data", bus.out_data, pd);
          check("hold_last", 64'(bus.out_last), 64'(pl));
        end
        if (bus.out_valid && bus.out_ready) begin
          sq_xfers++;
          check("word_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.d);
            check("out_last", 64'(bus.out_last), 64'(e.l));
          end
        end
        pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pl = bus.out_last;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_out_data"},  bus.out_data,       64'd0);
    check({tag, "_out_last"},  64'(bus.out_last),  64'd0);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_done"},      64'(bus.done),      64'd0);
    check({tag, "_perm_req"},  64'(bus.perm_req),  64'd0);
    check({tag, "_st_ready"},  64'(bus.st_ready),  64'd0);
  endtask

  task automatic begin_squeeze(input int n, input bit rnd, input bit fixed);
    @(posedge clk); #1;
    n_perm = 0; n_done = 0; sq_xfers = 0;
    model_rem = n; fixed_pat = fixed; ready_rand = rnd;
    bus.start = 1'b1;
    bus.out_words = LW'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_squeeze(input int n, input bit rnd, input bit fixed);
    int exp_perm;
    exp_perm = (n == 0) ? 0 : ((n + R - 1) / R - 1);
    begin_squeeze(n, rnd, fixed);
    check("busy_after_start", 64'(bus.busy), 64'(n != 0));
    if (n >= 8) begin
      // a start while busy must not disturb the running squeeze
      repeat (2) @(posedge clk); #1;
      bus.start = 1'b1;
      bus.out_words = LW'(7);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    for (int c = 0; c < 4000 && n_done == 0; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("done_pulses", 64'(n_done), 64'd1);
    check("perm_req_pulses", 64'(n_perm), 64'(exp_perm));
    check("transfers", 64'(sq_xfers), 64'(n));
    check("leftover_words", 64'(exp_q.size()), 64'd0);
    check("busy_at_end", 64'(bus.busy), 64'd0);
    exp_q.delete();
    ready_rand = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.out_words = '0;
    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    core_en = 1'b1;

    run_squeeze(4, 1'b0, 1'b1);
    run_squeeze(20, 1'b0, 1'b0);
    run_squeeze(17, 1'b0, 1'b0);
    run_squeeze(40, 1'b1, 1'b0);
    run_squeeze(0, 1'b0, 1'b0);

    // stray st_valid while idle must be ignored
    core_en = 1'b0;
    @(posedge clk); #1;
    bus.st_valid = 1'b1;
    check("idle_st_ready", 64'(bus.st_ready), 64'd0);
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    core_en = 1'b1;

    // reset in the middle of a squeeze, while lane 5 is being offered
    begin_squeeze(30, 1'b0, 1'b0);
    for (int c = 0; c < 200 && sq_xfers < 5; c++) @(negedge clk);
    check("xfers_before_rst", 64'(sq_xfers), 64'd5);
    @(posedge clk); #2;
    check("lane5_offered", bus.out_data, (exp_q.size() > 0) ? exp_q[0].d : 64'd0);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_rem = 0;
    run_squeeze(2, 1'b0, 1'b0);

    for (int t = 0; t < 4; t++) run_squeeze($urandom_range(60, 1), 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
